// File: rtl/seg_scan_ctrl_if.sv
// Load channel into the scan controller: value, per-digit blank mask and
// leading-zero enable, offered under a valid/ready handshake.
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] data_i;
    logic                load_valid_i;
    logic                load_ready_o;
    logic [DIGITS-1:0]   blank_i;
    logic                lzs_i;

    modport master (
        output data_i, load_valid_i, blank_i, lzs_i,
        input  load_ready_o
    );

    modport slave (
        input  data_i, load_valid_i, blank_i, lzs_i,
        output load_ready_o
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: one shared hex decoder, a one-deep
// pending buffer committed only at frame end, and guard-gapped active-low anodes.
module seg_scan_ctrl #(
    parameter int DIGITS = 8,
    parameter int DIV    = 50000,
    parameter int GUARD  = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_scan_ctrl_if.slave      ld,
    output logic [3:0]          dec_o,
    input  logic [6:0]          seg_i,
    output logic [6:0]          seg_o,
    output logic [DIGITS-1:0]   an_o,
    output logic                frame_o
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef struct packed {
        logic [DIGITS-1:0][3:0] data;
        logic [DIGITS-1:0]      blank;
        logic                   lzs;
    } disp_t;

    logic [PW-1:0]     p;
    logic [KW-1:0]     k;
    disp_t             disp;
    disp_t             pend;
    logic              pend_full;

    logic              p_last;
    logic              k_last;
    logic              frame_end;
    logic              accept;
    logic              in_guard;
    logic              eff_blank;
    logic [DIGITS-1:0] upper_zero;

    assign p_last          = (p == PW'(DIV - 1));
    assign k_last          = (k == KW'(DIGITS - 1));
    assign frame_end       = p_last && k_last;
    assign accept          = ld.load_valid_i && !pend_full;
    assign in_guard        = (p < PW'(GUARD));
    assign ld.load_ready_o = !pend_full;
    assign frame_o         = frame_end;
    assign dec_o           = disp.data[k];

    // upper_zero[j]: digit j and every digit above it hold zero.
    always_comb begin
        // NOTE: assign every bit up front so no path leaves it holding state (no latch).
        upper_zero = '0;
        upper_zero[DIGITS-1] = (disp.data[DIGITS-1] == 4'h0);
        for (int j = DIGITS - 2; j >= 0; j--) begin
            upper_zero[j] = upper_zero[j+1] && (disp.data[j] == 4'h0);
        end
    end

    assign eff_blank = disp.blank[k] || (disp.lzs && (k != '0) && upper_zero[k]);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
            k <= '0;
        end else if (p_last) begin
            p <= '0;
            k <= k_last ? '0 : k + 1'b1;
        end else begin
            p <= p + 1'b1;
        end
    end

    // Commit and accept never coincide: accept needs the buffer empty, commit needs it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp      <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
        end else if (frame_end && pend_full) begin
            disp      <= pend;
            pend_full <= 1'b0;
        end else if (accept) begin
            pend.data  <= ld.data_i;
            pend.blank <= ld.blank_i;
            pend.lzs   <= ld.lzs_i;
            pend_full  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_o  <= '1;
            seg_o <= 7'h7F;
        end else if (in_guard || eff_blank) begin
            an_o  <= '1;
            seg_o <= 7'h7F;
        end else begin
            an_o  <= ~(DIGITS'(1) << k);
            seg_o <= seg_i;
        end
    end
endmodule
